// File: rtl/sent_rx_frame_buffer_if.sv
// Bus bundle for the SENT receive frame buffer: the decoded-frame write side
// from the SENT receiver and the byte-read/status side toward the APB slave.
interface sent_rx_frame_buffer_if #(
    parameter int DATAWIDTH = 8
);
    // Decoded frame from the receive path (already in the PCLK domain)
    logic                 frame_valid;
    logic [1:0]           frame_type;
    logic [23:0]          frame_data;
    logic                 crc_ok;

    // Register-file side
    logic                 rd_byte;
    logic                 clr_ovf;
    logic [DATAWIDTH-1:0] reg_receive;
    logic                 byte_valid;
    logic [7:0]           reg_status;

    // Producer of frames / consumer of bytes
    modport master (
        output frame_valid, frame_type, frame_data, crc_ok, rd_byte, clr_ovf,
        input  reg_receive, byte_valid, reg_status
    );

    // The frame buffer itself
    modport slave (
        input  frame_valid, frame_type, frame_data, crc_ok, rd_byte, clr_ovf,
        output reg_receive, byte_valid, reg_status
    );
endinterface

// File: rtl/sent_rx_frame_buffer.sv
// SENT receive frame buffer. Stores CRC-checked frames in a small FIFO and
// hands the oldest frame to software one byte per receive-register read.
// Serial frames expose a single byte (data[7:0]); enhanced and fast frames
// expose three bytes, most significant first. Reserved-type frames are
// discarded without raising overflow.
module sent_rx_frame_buffer #(
    parameter int DEPTH     = 4,
    parameter int DATAWIDTH = 8
) (
    input  logic PCLK,
    input  logic PRESETn,
    sent_rx_frame_buffer_if.slave bus
);
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]   ONE_CNT  = CW'(1);
    localparam logic [1:0]      T_SERIAL = 2'b00;
    localparam logic [1:0]      T_RSVD   = 2'b11;
    localparam logic [1:0]      IDX_LAST = 2'd2;

    typedef struct packed {
        logic        crc_ok;
        logic [1:0]  ftype;
        logic [23:0] data;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic [AW-1:0]  rp_nxt;
    logic [CW-1:0]  cnt;
    logic [1:0]     idx;
    logic           ovf;

    entry_t         head;
    entry_t         in_entry;
    logic [1:0]     next_type;
    logic           empty;
    logic           full;
    logic           frame_in;
    logic           wr;
    logic           pop;
    logic           adv;
    logic           ovf_set;
    logic [1:0]     idx_nxt;
    logic [DATAWIDTH-1:0] head_byte;

    // Serial frames carry one byte and start on the last byte slot
    function automatic logic [1:0] start_idx(input logic [1:0] ftype);
        return (ftype == T_SERIAL) ? IDX_LAST : 2'd0;
    endfunction

    // Write/pop decisions and the next byte index
    always_comb begin
        empty     = (cnt == '0);
        full      = (cnt == FULL_CNT);
        rp_nxt    = rp + 1'b1;
        head      = mem[rp];
        next_type = mem[rp_nxt].ftype;
        in_entry  = '{crc_ok: bus.crc_ok, ftype: bus.frame_type, data: bus.frame_data};

        // Reading the last byte of the head frame retires it; earlier bytes
        // only step the index.
        pop = bus.rd_byte && !empty && idx[1];
        adv = bus.rd_byte && !empty && !idx[1];

        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        frame_in = bus.frame_valid && (bus.frame_type != T_RSVD);
        wr       = frame_in && (!full || pop);
        ovf_set  = frame_in && full && !pop;

        idx_nxt = idx;
        if (pop) begin
            // With one frame left, the next head is either the frame being
            // written right now (not yet in the array) or nothing.
            if (cnt == ONE_CNT)
                idx_nxt = wr ? start_idx(in_entry.ftype) : 2'd0;
            else
                idx_nxt = start_idx(next_type);
        end else if (adv) begin
            idx_nxt = idx + 2'd1;
        end else if (empty && wr) begin
            idx_nxt = start_idx(in_entry.ftype);
        end
    end

    // Frame storage; contents survive reset, validity is tracked by cnt
    always_ff @(posedge PCLK) begin
        if (wr)
            mem[wp] <= in_entry;
    end

    // Pointers, occupancy, byte index and sticky overflow
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            idx <= '0;
            ovf <= 1'b0;
        end else begin
            if (wr)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp_nxt;
            case ({wr, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            idx <= idx_nxt;
            // Set has priority over a clear in the same cycle
            if (ovf_set)
                ovf <= 1'b1;
            else if (bus.clr_ovf)
                ovf <= 1'b0;
        end
    end

    // Select the current byte of the head frame
    always_comb begin
        case (idx)
            2'd0:    head_byte = head.data[23:16];
            2'd1:    head_byte = head.data[15:8];
            default: head_byte = head.data[7:0];
        endcase
    end

    // Register-view outputs: pure decodes of state, zeroed while empty
    assign bus.reg_receive = empty ? '0 : head_byte;
    assign bus.byte_valid  = !empty;
    assign bus.reg_status  = {empty, full, ovf,
                              empty ? 5'b0 : {~head.crc_ok, head.ftype, idx}};

endmodule

// File: tb/tb_sent_rx_frame_buffer.sv
// Self-checking bench for sent_rx_frame_buffer. A byte-level scoreboard is
// filled when frames are driven and consumed as bytes are read back.
module tb_sent_rx_frame_buffer;
    localparam int DEPTH = 4;

    logic PCLK;
    logic PRESETn;

    sent_rx_frame_buffer_if #(.DATAWIDTH(8)) bif ();

    sent_rx_frame_buffer #(.DEPTH(DEPTH), .DATAWIDTH(8)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bif)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0] b;
        logic       crc;
        logic [1:0] ft;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt;
    logic m_ovf;
    int   checks;
    int   failures;

    function automatic logic [7:0] exp_status();
        if (exp_q.size() == 0)
            return {1'b1, 1'b0, m_ovf, 5'b0};
        return {1'b0, (m_cnt == DEPTH), m_ovf, ~exp_q[0].crc, exp_q[0].ft, exp_q[0].idx};
    endfunction

    function automatic logic [7:0] exp_byte();
        if (exp_q.size() == 0)
            return 8'h00;
        return exp_q[0].b;
    endfunction

    // One clock of stimulus, entered and left at a falling edge; the
    // scoreboard is updated from the pre-edge model state.
    task automatic drive(input logic fv, input logic [1:0] ft, input logic [23:0] d,
                         input logic crc, input logic rd, input logic clr);
        logic popframe;
        logic accept;
        int   pre_cnt;
        bif.frame_valid = fv;
        bif.frame_type  = ft;
        bif.frame_data  = d;
        bif.crc_ok      = crc;
        bif.rd_byte     = rd;
        bif.clr_ovf     = clr;
        pre_cnt  = m_cnt;
        popframe = 1'b0;
        if (rd && exp_q.size() > 0) begin
            popframe = exp_q[0].last;
            void'(exp_q.pop_front());
            if (popframe)
                m_cnt--;
        end
        accept = fv && (ft != 2'b11) && ((pre_cnt < DEPTH) || popframe);
        if (clr)
            m_ovf = 1'b0;
        if (fv && (ft != 2'b11) && !accept)
            m_ovf = 1'b1;
        if (accept) begin
            m_cnt++;
            if (ft == 2'b00) begin
                exp_q.push_back('{d[7:0], crc, ft, 2'd2, 1'b1});
            end else begin
                for (int k = 0; k < 3; k++)
                    exp_q.push_back('{d[23-8*k -: 8], crc, ft, 2'(k), (k == 2)});
            end
        end
        @(posedge PCLK);
        @(negedge PCLK);
        bif.frame_valid = 1'b0;
        bif.rd_byte     = 1'b0;
        bif.clr_ovf     = 1'b0;
    endtask

    task automatic apply_reset();
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // Read every outstanding byte, checking each one before it is consumed
    task automatic read_all(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            guard++;
            checks++;
            if (bif.byte_valid !== 1'b1 || bif.reg_receive !== exp_byte() ||
                bif.reg_status !== exp_status()) begin
                failures++;
                $display("FAIL %s_byte: got bv=%b rx=%h st=%h, expected bv=1 rx=%h st=%h",
                         name, bif.byte_valid, bif.reg_receive, bif.reg_status,
                         exp_byte(), exp_status());
            end
            drive(1'b0, 2'b00, 24'h0, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (bif.byte_valid !== 1'b0 || bif.reg_receive !== 8'h00 || bif.reg_status !== exp_status()) begin
            failures++;
            $display("FAIL %s_drained: got bv=%b rx=%h st=%h, expected bv=0 rx=00 st=%h",
                     name, bif.byte_valid, bif.reg_receive, bif.reg_status, exp_status());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bif.reg_status !== 8'h80 || bif.reg_receive !== 8'h00 || bif.byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got st=%h rx=%h bv=%b, expected st=80 rx=00 bv=0",
                     bif.reg_status, bif.reg_receive, bif.byte_valid);
        end
        drive(1'b0, 2'b00, 24'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bif.reg_status !== 8'h80 || bif.reg_receive !== 8'h00 || bif.byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_when_empty: got st=%h rx=%h bv=%b, expected st=80 rx=00 bv=0",
                     bif.reg_status, bif.reg_receive, bif.byte_valid);
        end
    endtask

    task automatic test_enhanced();
        drive(1'b1, 2'b01, 24'hA5C3F0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bif.reg_receive !== 8'hA5 || bif.reg_status !== 8'h04 || bif.byte_valid !== 1'b1) begin
            failures++;
            $display("FAIL enhanced_head: got rx=%h st=%h bv=%b, expected rx=A5 st=04 bv=1",
                     bif.reg_receive, bif.reg_status, bif.byte_valid);
        end
        read_all("enhanced");
        checks++;
        if (bif.reg_status !== 8'h80) begin
            failures++;
            $display("FAIL enhanced_empty: got st=%h, expected st=80", bif.reg_status);
        end
    endtask

    task automatic test_mixed_crc();
        drive(1'b1, 2'b00, 24'h00005A, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 24'h123456, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bif.reg_receive !== 8'h5A || bif.reg_status !== 8'h12) begin
            failures++;
            $display("FAIL serial_crc_head: got rx=%h st=%h, expected rx=5A st=12",
                     bif.reg_receive, bif.reg_status);
        end
        drive(1'b0, 2'b00, 24'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bif.reg_receive !== 8'h12 || bif.reg_status !== 8'h08) begin
            failures++;
            $display("FAIL fast_after_pop: got rx=%h st=%h, expected rx=12 st=08",
                     bif.reg_receive, bif.reg_status);
        end
        read_all("mixed");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++)
            drive(1'b1, 2'b01, 24'h100000 * (i + 1) + 24'h0000AB, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bif.reg_status[6] !== 1'b1 || bif.reg_status[5] !== 1'b1 || bif.reg_status !== exp_status()) begin
            failures++;
            $display("FAIL overflow_flags: got st=%h, expected st=%h (full and overflow set)",
                     bif.reg_status, exp_status());
        end
        drive(1'b0, 2'b00, 24'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bif.reg_status[5] !== 1'b0 || bif.reg_status !== exp_status()) begin
            failures++;
            $display("FAIL overflow_clear: got st=%h, expected st=%h", bif.reg_status, exp_status());
        end
        read_all("overflow");
    endtask

    task automatic test_simul_write_pop();
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, 2'b00, 24'(8'h31 + i), 1'b1, 1'b0, 1'b0);
        // Head is a serial frame at its last byte, so this read retires it
        drive(1'b1, 2'b10, 24'hBEEF77, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bif.reg_status[6] !== 1'b1 || bif.reg_status[5] !== 1'b0 ||
            bif.reg_receive !== 8'h32 || bif.reg_status !== exp_status()) begin
            failures++;
            $display("FAIL write_pop_full: got rx=%h st=%h, expected rx=32 st=%h",
                     bif.reg_receive, bif.reg_status, exp_status());
        end
        read_all("write_pop");
    endtask

    task automatic test_reserved_wrap();
        logic [1:0]  ft;
        logic [23:0] d;
        drive(1'b1, 2'b11, 24'hDEAD00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bif.reg_status !== 8'h80 || bif.byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL reserved_drop: got st=%h bv=%b, expected st=80 bv=0",
                     bif.reg_status, bif.byte_valid);
        end
        for (int i = 0; i < 10; i++) begin
            ft = 2'($urandom_range(0, 2));
            d  = 24'($urandom);
            drive(1'b1, ft, d, 1'($urandom), 1'b0, 1'b0);
            // Odd rounds write a second frame while the first byte is read
            if (i % 2 == 1)
                drive(1'b1, 2'($urandom_range(0, 2)), 24'($urandom), 1'($urandom), 1'b1, 1'b0);
            read_all("wrap");
        end
    endtask

    task automatic test_reset_mid_frame();
        drive(1'b1, 2'b01, 24'h010203, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 24'h040506, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 24'h0, 1'b0, 1'b1, 1'b0);
        apply_reset();
        checks++;
        if (bif.reg_status !== 8'h80 || bif.reg_receive !== 8'h00 || bif.byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_frame: got st=%h rx=%h bv=%b, expected st=80 rx=00 bv=0",
                     bif.reg_status, bif.reg_receive, bif.byte_valid);
        end
        drive(1'b1, 2'b00, 24'h0000C7, 1'b1, 1'b0, 1'b0);
        read_all("after_reset");
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        m_cnt           = 0;
        m_ovf           = 1'b0;
        PRESETn         = 1'b0;
        bif.frame_valid = 1'b0;
        bif.frame_type  = 2'b00;
        bif.frame_data  = 24'h0;
        bif.crc_ok      = 1'b0;
        bif.rd_byte     = 1'b0;
        bif.clr_ovf     = 1'b0;
        @(negedge PCLK);
        test_reset();
        test_enhanced();
        test_mixed_crc();
        test_overflow();
        test_simul_write_pop();
        test_reserved_wrap();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
